// File: rtl/dp_regfile_arbiter_pkg.sv
// Shared definitions for the PE register-file arbiter: width helpers and the
// default regfile geometry.
package dp_regfile_arbiter_pkg;

   localparam int PE_ADDR_LEN = 5;
   localparam int PE_DATA_LEN = 32;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Low bit of requester idx inside a flattened bus of width-wide slices.
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/dp_regfile_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from a pointer that
// moves past the winner and holds when nobody requests.
module rr_arbiter
   import dp_regfile_arbiter_pkg::*;
#(
   parameter int N       = 2,
   parameter int IDX_LEN = (clog2(N) > 0) ? clog2(N) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       req,
   output logic [N-1:0]       grant,
   output logic [IDX_LEN-1:0] grant_idx,
   output logic               grant_any
);

   logic [IDX_LEN-1:0] ptr_reg;
   logic [IDX_LEN-1:0] ptr_next;
   logic [N-1:0]       mask;
   logic [N-1:0]       masked_req;
   logic [N-1:0]       pick;
   logic [N-1:0]       first;
   logic [N-1:0]       idx_col [IDX_LEN];

   // Requesters at or above the pointer take precedence; otherwise wrap.
   for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = (IDX_LEN'(gi) >= ptr_reg);
   end

   assign masked_req = req & mask;
   assign pick       = (|masked_req) ? masked_req : req;

   for (genvar gi = 0; gi < N; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
         assign first[gi] = pick[gi];
      end else begin : g_upper
         assign first[gi] = pick[gi] & ~(|pick[gi-1:0]);
      end
   end

   // One-hot to binary: each index bit ORs the grants whose position has it set.
   for (genvar gb = 0; gb < IDX_LEN; gb++) begin : g_enc_bit
      for (genvar gi = 0; gi < N; gi++) begin : g_enc_req
         if (((gi >> gb) & 1) == 1) begin : g_set
            assign idx_col[gb][gi] = first[gi];
         end else begin : g_clr
            assign idx_col[gb][gi] = 1'b0;
         end
      end
      assign grant_idx[gb] = |idx_col[gb];
   end

   assign grant     = reset ? '0 : first;
   assign grant_any = |grant;

   always_comb begin
      ptr_next = ptr_reg;
      if (grant_any) begin
         if (grant_idx == IDX_LEN'(N - 1)) ptr_next = '0;
         else                              ptr_next = grant_idx + IDX_LEN'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_reg <= '0;
      else       ptr_reg <= ptr_next;
   end

endmodule

// File: rtl/dp_regfile_arbiter.sv
// Shares one 1W/1R register file between several write and read requesters,
// with registered port drive, tagged read return and write-to-read forwarding.
module dp_regfile_arbiter
   import dp_regfile_arbiter_pkg::*;
#(
   parameter int ADDR_LEN = PE_ADDR_LEN,
   parameter int DATA_LEN = PE_DATA_LEN,
   parameter int NUM_WR   = 3,
   parameter int NUM_RD   = 2,
   parameter int ID_LEN   = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_WR-1:0]            wr_req,
   input  logic [NUM_WR*ADDR_LEN-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_LEN-1:0]   wr_data,
   output logic [NUM_WR-1:0]            wr_ack,
   input  logic [NUM_RD-1:0]            rd_req,
   input  logic [NUM_RD*ADDR_LEN-1:0]   rd_addr,
   output logic [NUM_RD-1:0]            rd_ack,
   output logic                         rd_valid,
   output logic [ID_LEN-1:0]            rd_id,
   output logic [DATA_LEN-1:0]          rd_data,
   output logic                         rf_wrt,
   output logic [ADDR_LEN-1:0]          rf_wrt_addr,
   output logic [DATA_LEN-1:0]          rf_data_in,
   output logic                         rf_rd,
   output logic [ADDR_LEN-1:0]          rf_rd_addr,
   input  logic [DATA_LEN-1:0]          rf_data_out
);

   localparam int WI_LEN = (clog2(NUM_WR) > 0) ? clog2(NUM_WR) : 1;
   localparam int RI_LEN = (clog2(NUM_RD) > 0) ? clog2(NUM_RD) : 1;

   logic [ADDR_LEN-1:0] wr_addr_arr [NUM_WR];
   logic [DATA_LEN-1:0] wr_data_arr [NUM_WR];
   logic [ADDR_LEN-1:0] rd_addr_arr [NUM_RD];

   for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
      assign wr_addr_arr[gi] = wr_addr[slice_lo(gi, ADDR_LEN) +: ADDR_LEN];
      assign wr_data_arr[gi] = wr_data[slice_lo(gi, DATA_LEN) +: DATA_LEN];
   end

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_unpack
      assign rd_addr_arr[gi] = rd_addr[slice_lo(gi, ADDR_LEN) +: ADDR_LEN];
   end

   logic [WI_LEN-1:0] wr_idx;
   logic              wr_any;
   logic [RI_LEN-1:0] rd_idx;
   logic              rd_any;

   rr_arbiter #(.N(NUM_WR), .IDX_LEN(WI_LEN)) u_wr_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (wr_req),
      .grant     (wr_ack),
      .grant_idx (wr_idx),
      .grant_any (wr_any)
   );

   rr_arbiter #(.N(NUM_RD), .IDX_LEN(RI_LEN)) u_rd_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (rd_req),
      .grant     (rd_ack),
      .grant_idx (rd_idx),
      .grant_any (rd_any)
   );

   logic                rf_wrt_reg;
   logic [ADDR_LEN-1:0] rf_wrt_addr_reg;
   logic [DATA_LEN-1:0] rf_data_in_reg;
   logic                rf_rd_reg;
   logic [ADDR_LEN-1:0] rf_rd_addr_reg;
   logic [ID_LEN-1:0]   rd_pend_id_reg;
   logic                rd_valid_reg;
   logic [ID_LEN-1:0]   rd_id_reg;
   logic [DATA_LEN-1:0] rd_data_reg;
   logic                fwd;

   // A write landing this cycle on the address being read wins over the array.
   assign fwd = rf_wrt_reg && rf_rd_reg && (rf_wrt_addr_reg == rf_rd_addr_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_wrt_reg      <= 1'b0;
         rf_wrt_addr_reg <= '0;
         rf_data_in_reg  <= '0;
         rf_rd_reg       <= 1'b0;
         rf_rd_addr_reg  <= '0;
         rd_pend_id_reg  <= '0;
         rd_valid_reg    <= 1'b0;
         rd_id_reg       <= '0;
         rd_data_reg     <= '0;
      end else begin
         rf_wrt_reg <= wr_any;
         if (wr_any) begin
            rf_wrt_addr_reg <= wr_addr_arr[wr_idx];
            rf_data_in_reg  <= wr_data_arr[wr_idx];
         end
         rf_rd_reg <= rd_any;
         if (rd_any) begin
            rf_rd_addr_reg <= rd_addr_arr[rd_idx];
            rd_pend_id_reg <= ID_LEN'(rd_idx);
         end
         rd_valid_reg <= rf_rd_reg;
         if (rf_rd_reg) begin
            rd_data_reg <= fwd ? rf_data_in_reg : rf_data_out;
            rd_id_reg   <= rd_pend_id_reg;
         end
      end
   end

   assign rf_wrt      = rf_wrt_reg;
   assign rf_wrt_addr = rf_wrt_addr_reg;
   assign rf_data_in  = rf_data_in_reg;
   assign rf_rd       = rf_rd_reg;
   assign rf_rd_addr  = rf_rd_addr_reg;
   assign rd_valid    = rd_valid_reg;
   assign rd_id       = rd_id_reg;
   assign rd_data     = rd_data_reg;

endmodule

// File: doc/dp_regfile_arbiter.md
Name: dp_regfile_arbiter

Overview:
- Shares one dual-port register file (1 write port, 1 combinational read port, `2^ADDR_LEN` x `DATA_LEN`) between `NUM_WR` write requesters and `NUM_RD` read requesters inside a PE.
- Round-robin arbitration on each port. Registered drive of the regfile ports.
- Registered read return with requester ID.
- Same-cycle write-to-read forwarding keeps ordering coherent.

Parameters:
- `ADDR_LEN`, 5, regfile address width
- `DATA_LEN`, 32, data width
- `NUM_WR`, 3, write requesters (min 1, max 8)
- `NUM_RD`, 2, read requesters (min 1, max 8)
- `ID_LEN`, 1, width of `rd_id`; must be ≥ `clog2(NUM_RD)`, min 1

Ports:
- `clk`  in  1  clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `wr_req`  in  `NUM_WR`  write request per requester; held until acked
- `wr_addr`  in  `NUM_WR*ADDR_LEN`  flattened write addresses; requester i at slice i
- `wr_data`  in  `NUM_WR*DATA_LEN`  flattened write data
- `wr_ack`  out  `NUM_WR`  one-hot combinational grant; the request is consumed this cycle
- `rd_req`  in  `NUM_RD`  read request; held until acked
- `rd_addr`  in  `NUM_RD*ADDR_LEN`  flattened read addresses
- `rd_ack`  out  `NUM_RD`  one-hot combinational grant
- `rd_valid`  out  1  read data valid, one-cycle pulse
- `rd_id`  out  `ID_LEN`  index of the requester owning `rd_data`
- `rd_data`  out  `DATA_LEN`  returned read data
- `rf_wrt`  out  1  regfile write enable
- `rf_wrt_addr`  out  `ADDR_LEN`  regfile write address
- `rf_data_in`  out  `DATA_LEN`  regfile write data
- `rf_rd`  out  1  regfile read strobe
- `rf_rd_addr`  out  `ADDR_LEN`  regfile read address
- `rf_data_out`  in  `DATA_LEN`  regfile combinational read data

Behaviour:
- **Reset (sync):**
  - `rf_wrt`, `rf_rd`, `rd_valid` = 0.
  - `rf_wrt_addr`, `rf_rd_addr`, `rf_data_in`, `rd_data`, `rd_id` = 0.
  - Both round-robin pointers = 0.
  - `wr_ack` and `rd_ack` forced to 0 while `reset` is high.
  - In-flight reads are dropped: no `rd_valid` after reset.
- **Arbitration (cycle t), identical for write and read sides:**
  - Scan requesters starting at pointer p, ascending with wrap.
  - The first asserted req gets ack in cycle t.
  - At the edge, p <= granted+1 mod N. With no request, p is held.
  - At most one grant per side per cycle.
  - Any active requester is granted within N cycles (no starvation).
- **Write path:**
  - On the grant edge, register `rf_wrt`=1, `rf_wrt_addr`/`rf_data_in` from the granted slice.
  - Drive them during t+1. The regfile commits at the end of t+1.
  - `rf_wrt`=0 in cycles following no grant.
  - Throughput: 1 write/cycle.
- **Read path:**
  - On the grant edge, register `rf_rd`=1, `rf_rd_addr`, and an internal ID.
  - During t+1, capture data on the closing edge: `rd_data` <= `rf_data_out`, `rd_valid` <= 1, `rd_id` <= ID.
  - `rd_valid` is high in t+2, giving 2-cycle latency from ack to data.
  - Throughput: 1 read/cycle, fully pipelined.
  - `rd_valid` = 0 in any cycle whose t+1 had `rf_rd`=0.
- **Forwarding:**
  - In t+1, if `rf_wrt` && `rf_rd` && `rf_wrt_addr`==`rf_rd_addr`, capture `rf_data_in` instead of `rf_data_out`.
  - Result: a read and write acked in the same cycle to the same address return the NEW data (write wins).
  - A read acked strictly before the write returns the old value.
  - A read acked after the write returns new data via the regfile.
- **Ack timing:** acks depend combinationally on req and registered pointers only. No combinational path from `rf_data_out` to any ack.
- **Requester rules:**
  - A requester must not change addr/data while req is high and unacked.
  - Deasserting req before ack is allowed (request withdrawn).
- **Width rules:** no arithmetic beyond the pointer increment, which wraps modulo N for non-power-of-2 N.

Decomposition:
- Shared package holds:
  - the `clog2` function
  - the flattened-slice index helper
  - a default `ADDR_LEN`/`DATA_LEN` pair matching the PE regfile
- One natural sub-module, `rr_arbiter` (parameter N: req -> one-hot grant, pointer register, hold when idle). It is instantiated twice, for the write and read sides.
- The top level holds the port registers and forwarding mux.

Test Plan:
1. Reset mid-stream: reads issued to addr 3 then reset asserted in the ack+1 cycle -> no `rd_valid`; all outputs 0 the cycle after reset; pointers 0.
2. Single write/read: writer 0 writes `0xDEADBEEF` to addr 5 at t0, reader 0 reads addr 5 at t2 -> `rf_wrt`=1 at t1; `rd_valid`=1, `rd_data`=`0xDEADBEEF`, `rd_id`=0 at t4.
3. Round-robin: all 3 writers request continuously to addrs 1,2,3 -> `wr_ack` sequence 001,010,100,001; `rf_wrt_addr` 1,2,3,1 one cycle later.
4. Same-cycle hazard: addr 7 holds `0x11`; write `0x22` to addr 7 and read addr 7 acked the same cycle -> `rd_data`=`0x22`. Read acked one cycle before the write -> `0x11`.
5. Back-to-back reads: readers 0 and 1 both request addrs 4 and 9 (holding `0xA`/`0xB`) -> acks 01 then 10; `rd_valid` 2 consecutive cycles, (`rd_id`,`rd_data`) = (0,`0xA`),(1,`0xB`).
6. Idle/withdraw: writer 1 raises req then drops it before grant while writer 0 holds priority -> writer 1 never acked, `rf_wrt` shows only writer 0's write, pointer advances to 1.
